// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared definitions for the reusable pipeline-stage register:
//   - psr_state_e : fill state of the two-entry skid variant
//                   (PSR_EMPTY / PSR_ONE / PSR_FULL, numerically equal to the
//                   number of held entries so it can drive `occupancy` directly)
//   - ZeroWord    : canonical 32-bit zero used by stage logic and benches
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PSR_EMPTY = 2'd0,
        PSR_ONE   = 2'd1,
        PSR_FULL  = 2'd2
    } psr_state_e;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Valid/ready payload channel between two pipeline stages.
//   valid : producer offers `data`
//   ready : consumer accepts `data` this cycle
//   data  : WIDTH-bit payload bundle
// Modports:
//   master : producer side (drives valid/data, observes ready)
//   slave  : consumer side (observes valid/data, drives ready)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);

endinterface : pipe_stage_reg_if

// File: rtl/pipe_hold_reg.sv
// -----------------------------------------------------------------------------
// pipe_hold_reg
// WIDTH-bit data register with load and clear. Holds its value when neither
// load nor clear is active. Clear wins over load.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (zeroes the register)
//   load  : capture `d` at the next edge
//   clear : zero the register at the next edge
//   d     : data in
//   q     : registered data out
// -----------------------------------------------------------------------------
module pipe_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: the payload is reset even though valid alone would suffice --
    // downstream stages expect a defined all-zero bundle out of reset.
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : pipe_hold_reg

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Reusable pipeline-stage register carrying a WIDTH-bit payload with a
// valid/ready handshake and flush.
//   SKID=0 : single register, in_ready depends combinationally on out_ready.
//   SKID=1 : two-entry skid buffer, in_ready comes from a register (gated only
//            by rst), so backpressure does not ripple combinationally.
//   CLEAR_ON_FLUSH=1 zeroes the payload registers on flush; 0 clears only
//   the valid state.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (priority over flush)
//   flush     : discard all held entries (priority over handshakes)
//   up        : upstream channel (slave): valid/data in, ready out
//   dn        : downstream channel (master): valid/data out, ready in
//   occupancy : number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit SKID           = 1'b1,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    pipe_stage_reg_if.slave        up,
    pipe_stage_reg_if.master       dn,
    output logic [1:0]             occupancy
);

    logic             in_fire;
    logic             out_fire;
    logic             clear_data;
    logic             main_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic             main_valid;

    assign in_fire    = up.valid & up.ready;
    assign out_fire   = dn.valid & dn.ready;
    assign clear_data = flush & CLEAR_ON_FLUSH;

    assign dn.valid = main_valid;
    assign dn.data  = main_q;

    pipe_hold_reg #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (clear_data),
        .d     (main_d),
        .q     (main_q)
    );

    if (SKID) begin : g_skid
        psr_state_e       state_q;
        psr_state_e       state_d;
        logic             ready_q;
        logic             skid_load;
        logic             main_from_skid;
        logic [WIDTH-1:0] skid_q;

        pipe_hold_reg #(.WIDTH(WIDTH)) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (skid_load),
            .clear (clear_data),
            .d     (up.data),
            .q     (skid_q)
        );

        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned (which would infer a latch).
        always_comb begin
            state_d        = state_q;
            main_load      = 1'b0;
            skid_load      = 1'b0;
            main_from_skid = 1'b0;
            case (state_q)
                PSR_EMPTY: begin
                    if (in_fire) begin
                        state_d   = PSR_ONE;
                        main_load = 1'b1;
                    end
                end
                PSR_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = PSR_FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = PSR_EMPTY;
                    end
                end
                PSR_FULL: begin
                    // No input is accepted here; draining promotes skid to main.
                    if (out_fire) begin
                        state_d        = PSR_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = PSR_EMPTY;
            endcase
            // A flush discards any same-cycle transfer and empties the block.
            if (flush) begin
                state_d        = PSR_EMPTY;
                main_load      = 1'b0;
                skid_load      = 1'b0;
                main_from_skid = 1'b0;
            end
        end

        // ready_q tracks "next state is not FULL", so it equals
        // (state_q != PSR_FULL) at all times without a combinational path
        // from out_ready.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= PSR_EMPTY;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                ready_q <= (state_d != PSR_FULL);
            end
        end

        assign main_d     = main_from_skid ? skid_q : up.data;
        assign main_valid = (state_q != PSR_EMPTY);
        assign up.ready   = ~rst & ready_q;
        assign occupancy  = state_q;
    end else begin : g_single
        logic valid_q;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                valid_q <= 1'b0;
            end else if (in_fire) begin
                valid_q <= 1'b1;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end

        assign main_load  = in_fire & ~flush;
        assign main_d     = up.data;
        assign main_valid = valid_q;
        assign up.ready   = ~rst & (dn.ready | ~valid_q);
        assign occupancy  = {1'b0, valid_q};
    end

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Three 102-bit instances driven side by side:
//   0 : SKID=1, CLEAR_ON_FLUSH=1
//   1 : SKID=0, CLEAR_ON_FLUSH=1
//   2 : SKID=1, CLEAR_ON_FLUSH=0
// A queue-style model (entry count + up to two payloads) predicts every
// output; a negedge process compares all instances each cycle. Directed
// sequences add literal expectations, followed by 10k random cycles.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int W = 102;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N-1:0] flush;
    logic [N-1:0] in_valid;
    logic [N-1:0] out_ready;
    logic [N-1:0] in_ready;
    logic [N-1:0] out_valid;
    logic [W-1:0] in_data  [N];
    logic [W-1:0] out_data [N];
    logic [1:0]   occ      [N];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        pipe_stage_reg_if #(.WIDTH(W)) up ();
        pipe_stage_reg_if #(.WIDTH(W)) dn ();

        assign up.valid     = in_valid[g];
        assign up.data      = in_data[g];
        assign in_ready[g]  = up.ready;
        assign out_valid[g] = dn.valid;
        assign out_data[g]  = dn.data;
        assign dn.ready     = out_ready[g];

        pipe_stage_reg #(
            .WIDTH          (W),
            .SKID           (g != 1),
            .CLEAR_ON_FLUSH (g != 2)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush[g]),
            .up        (up),
            .dn        (dn),
            .occupancy (occ[g])
        );
    end

    // ---------------- behavioural model ----------------
    int           m_cnt [N];
    logic [W-1:0] m_q   [N][2];

    function automatic bit m_skid(input int g);
        return g != 1;
    endfunction

    function automatic logic m_in_ready(input int g);
        if (rst) return 1'b0;
        if (m_skid(g)) return m_cnt[g] < 2;
        return out_ready[g] || (m_cnt[g] == 0);
    endfunction

    task automatic model_step(input int g);
        bit in_f;
        bit out_f;
        if (rst || flush[g]) begin
            m_cnt[g] = 0;
            return;
        end
        in_f  = in_valid[g] && m_in_ready(g);
        out_f = (m_cnt[g] > 0) && out_ready[g];
        if (out_f) begin
            m_q[g][0] = m_q[g][1];
            m_cnt[g]--;
        end
        if (in_f) begin
            m_q[g][m_cnt[g]] = in_data[g];
            m_cnt[g]++;
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input int g);
        check($sformatf("in_ready[%0d]", g), 128'(in_ready[g]), 128'(m_in_ready(g)));
        check($sformatf("out_valid[%0d]", g), 128'(out_valid[g]), 128'(m_cnt[g] > 0));
        check($sformatf("occupancy[%0d]", g), 128'(occ[g]), 128'(m_cnt[g]));
        if (m_cnt[g] > 0)
            check($sformatf("out_data[%0d]", g), 128'(out_data[g]), 128'(m_q[g][0]));
    endtask

    initial begin
        for (int g = 0; g < N; g++) m_cnt[g] = 0;
        forever begin
            @(posedge clk);
            for (int g = 0; g < N; g++) model_step(g);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < N; g++) check_cycle(g);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
        for (int g = 0; g < N; g++) begin
            in_valid[g]  = v;
            in_data[g]   = d;
            out_ready[g] = ordy;
            flush[g]     = fl;
        end
    endtask

    initial begin
        logic [127:0] r;

        drive(1'b0, '0, 1'b1, 1'b0);
        rst = 1'b1;

        // Reset / idle
        cycle();
        check("rst in_ready",  128'(in_ready[0]),  128'(0));
        check("rst out_valid", 128'(out_valid[0]), 128'(0));
        check("rst out_data",  128'(out_data[0]),  128'(ZeroWord));
        check("rst occupancy", 128'(occ[0]),       128'(0));
        cycle();
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 128'(in_ready[0]), 128'(1));

        // Streaming, out_ready held high
        drive(1'b1, 'h11, 1'b1, 1'b0); cycle();
        check("stream d0", 128'(out_data[0]), 128'(8'h11));
        check("stream occ0", 128'(occ[0]), 128'(1));
        drive(1'b1, 'h22, 1'b1, 1'b0); cycle();
        check("stream d1", 128'(out_data[0]), 128'(8'h22));
        check("stream rdy1", 128'(in_ready[0]), 128'(1));
        drive(1'b1, 'h33, 1'b1, 1'b0); cycle();
        check("stream d2", 128'(out_data[0]), 128'(8'h33));
        check("stream occ2", 128'(occ[0]), 128'(1));
        drive(1'b0, '0, 1'b1, 1'b0); cycle();
        check("stream drained", 128'(occ[0]), 128'(0));

        // Backpressure into the skid entry
        drive(1'b1, 'hA0, 1'b1, 1'b0); cycle();
        drive(1'b1, 'hA1, 1'b0, 1'b0); cycle();
        check("bp occ full", 128'(occ[0]), 128'(2));
        check("bp in_ready", 128'(in_ready[0]), 128'(0));
        check("bp head", 128'(out_data[0]), 128'(8'hA0));
        drive(1'b1, 'hA2, 1'b0, 1'b0); cycle();
        check("bp hold occ", 128'(occ[0]), 128'(2));
        check("bp hold head", 128'(out_data[0]), 128'(8'hA0));
        drive(1'b1, 'hA2, 1'b1, 1'b0); cycle();
        check("bp drain1", 128'(out_data[0]), 128'(8'hA1));
        check("bp ready back", 128'(in_ready[0]), 128'(1));
        drive(1'b1, 'hA2, 1'b1, 1'b0); cycle();
        check("bp drain2", 128'(out_data[0]), 128'(8'hA2));
        drive(1'b0, '0, 1'b1, 1'b0); cycle();
        check("bp empty", 128'(occ[0]), 128'(0));

        // Flush while FULL with a competing input
        drive(1'b1, 'hB0, 1'b0, 1'b0); cycle();
        drive(1'b1, 'hB1, 1'b0, 1'b0); cycle();
        check("pre-flush occ", 128'(occ[0]), 128'(2));
        drive(1'b1, 'hFF, 1'b0, 1'b1); cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("flush occ", 128'(occ[0]), 128'(0));
        check("flush valid", 128'(out_valid[0]), 128'(0));
        check("flush data cleared", 128'(out_data[0]), 128'(0));
        check("flush data kept", 128'(out_data[2]), 128'(8'hB0));
        cycle();
        check("flush no ghost", 128'(out_valid[0]), 128'(0));

        // SKID=0 combinational stall
        drive(1'b1, 'hC0, 1'b1, 1'b0); cycle();
        drive(1'b1, 'hC1, 1'b0, 1'b0); #1;
        check("s0 stall ready", 128'(in_ready[1]), 128'(0));
        check("s0 stall data", 128'(out_data[1]), 128'(8'hC0));
        cycle();
        check("s0 held data", 128'(out_data[1]), 128'(8'hC0));
        drive(1'b1, 'hC1, 1'b1, 1'b0); #1;
        check("s0 release ready", 128'(in_ready[1]), 128'(1));
        cycle();
        check("s0 next data", 128'(out_data[1]), 128'(8'hC1));
        drive(1'b0, '0, 1'b1, 1'b0); cycle();

        // Reset mid-transfer
        drive(1'b1, 'hD0, 1'b0, 1'b0); cycle();
        drive(1'b1, 'hD1, 1'b0, 1'b0); cycle();
        rst = 1'b1; cycle();
        check("midrst occ", 128'(occ[0]), 128'(0));
        check("midrst ready", 128'(in_ready[0]), 128'(0));
        rst = 1'b0; drive(1'b0, '0, 1'b1, 1'b0); cycle();

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int g = 0; g < N; g++) begin
                r = {$urandom, $urandom, $urandom, $urandom};
                in_valid[g]  = ($urandom_range(0, 3) != 0);
                in_data[g]   = r[W-1:0];
                out_ready[g] = ($urandom_range(0, 2) != 0);
                flush[g]     = ($urandom_range(0, 49) == 0);
            end
            cycle();
        end

        rst = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        cycle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register that replaces the fixed per-stage registers (IF/ID … MEM/WB) with one reusable block. It carries an arbitrary-width payload bundle with a valid/ready handshake and flush. An optional two-entry skid buffer registers the backpressure path, so stalls no longer have to be broadcast combinationally across the whole pipeline. One instance sits between each pair of adjacent stages; the stage logic packs its fields into `in_data` and unpacks `out_data`.

## Interface
- `WIDTH`, 32: payload width in bits; must be ≥ 1.
- `SKID`, 1: 0 = single register with combinational ready; 1 = two-entry skid buffer with registered ready.
- `CLEAR_ON_FLUSH`, 1: 1 = payload registers are zeroed on flush; 0 = only the valid bits are cleared.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discards all held entries (exception/branch redirect).
- `in_valid`  in  1  upstream stage offers `in_data`.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_ready`  in  1  downstream stage consumes this cycle.
- `out_data`  out  WIDTH  payload of the oldest entry.
- `occupancy`  out  2  number of held entries, 0..2. Never exceeds 1 when `SKID=0`.

## Operation
- Handshakes:
  - in_fire = `in_valid & in_ready`.
  - out_fire = `out_valid & out_ready`.
- `out_data` is the main register. `out_valid` is the main-register valid bit.
- Priority on every edge: `rst` > `flush` > handshake.
- Reset sets: state EMPTY, both valid bits 0, both data registers 0, `occupancy`=0, `out_valid`=0, `out_data`=0. `in_ready` is held 0 while `rst`=1.
- Flush moves the block to EMPTY and clears both valid bits. The payload is zeroed only if `CLEAR_ON_FLUSH`=1. An in_fire in the same cycle as a flush is discarded. Upstream is flushed by the same signal.
- `SKID=0`:
  - `in_ready = ~rst & (out_ready | ~out_valid)`.
  - On in_fire, main is loaded and valid is set.
  - On out_fire without in_fire, valid is cleared.
- `SKID=1` state machine; `in_ready = ~rst & (state != FULL)` and is a pure register output:
  - EMPTY: in_fire → ONE, main ← in.
  - ONE:
    - in_fire & out_fire → ONE, main ← in.
    - in_fire & !out_fire → FULL, skid ← in.
    - out_fire only → EMPTY.
    - otherwise hold.
  - FULL: out_fire → ONE, main ← skid; otherwise hold. No input is accepted in FULL.
- Ordering is strict FIFO; no entry is dropped or duplicated except by flush or reset.
- `occupancy` is 0/1/2 for EMPTY/ONE/FULL.
- A data register holds its last value when not loaded; `out_data` is don't-care while `out_valid`=0.

## Timing
- Latency: in_fire at edge N gives `out_valid`=1 with that payload after edge N, i.e. one cycle.
- Throughput: one entry per cycle when `out_ready` is held at 1.
- `SKID=1` with `out_ready` deasserted while streaming:
  - Exactly one additional entry is absorbed, going to FULL.
  - `in_ready` drops the cycle after that absorption.
  - After `out_ready` reasserts, `in_ready` returns one cycle after the first out_fire.
- `SKID=0`: `in_ready` depends combinationally on `out_ready`, which must be accounted for in timing closure.
- `flush` and `rst` take effect at the edge where they are sampled high. Outputs reflect the emptied state in the following cycle.
- Reset mid-transfer: any entry in flight is lost. There is no partial-state carry-over.

## Structure
- State encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2 go in the shared defines header as `PSR_EMPTY`/`PSR_ONE`/`PSR_FULL`, next to `ZeroWord`.
- Sub-module `pipe_hold_reg`: a WIDTH-bit register with load and clear.
  - Instantiated for main.
  - Instantiated for skid under `generate` when `SKID=1`.
- Stage-specific bundle packing stays in the instantiating stage, not in this block.

## Test plan
- Reset/idle: `rst`=1 for 2 cycles, then 0 → `out_valid`=0, `out_data`=0, `occupancy`=0, `in_ready`=0 during reset and 1 one cycle after.
- Streaming, `SKID=1`, `out_ready`=1: inputs 0x11, 0x22, 0x33 on consecutive cycles → `out_data` shows the same values one cycle later, `occupancy` stays 1, `in_ready` stays 1.
- Backpressure, `SKID=1`:
  - Stimulus: stream 0xA0, 0xA1, 0xA2 with `out_ready`=0 from the cycle 0xA0 appears.
  - Required: 0xA1 is absorbed, `occupancy`=2, `in_ready`=0, and 0xA2 is held off until space frees.
  - On `out_ready`=1, outputs appear in the order 0xA0, 0xA1, 0xA2 with no loss.
- Flush in FULL, `CLEAR_ON_FLUSH`=1: `flush`=1 with `in_valid`=1 (0xFF) → next cycle `occupancy`=0, `out_valid`=0, `out_data`=0, and 0xFF never appears.
- `SKID=0` stall: `out_ready`=0 while `out_valid`=1 → `in_ready`=0 in the same cycle, and the payload is held until `out_ready`=1.
- `WIDTH=102` (a MEM/WB-sized bundle), random valid/ready for 10k cycles → scoreboard shows exact FIFO order and `occupancy` matches the model every cycle.
